trigger_monitor: RTL and testbench
==================================

# trigger_monitor

Target-side input monitor for the glitcher: it watches the asynchronous trigger/status line coming back from the target device and converts a qualified edge or level into a single-cycle `trig_o` pulse for the downstream delay/glitch logic. It is the receive counterpart of the reset driver. The reset driver pushes a pulse into the target, and this block observes the target's response. Each trigger capture is one-shot. It reports arm-to-trigger latency, and it can time out if the target never responds.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages in the input synchronizer. Minimum 2.
- `CNT_W`, default 16: width of the timeout and latency counters.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, synchronous, active-low. There is one clock domain.
- `trig_i` input 1: raw line from the target. It is asynchronous to `clk`.
- `arm_i` input 1: request to arm. It is accepted only in IDLE.
- `abort_i` input 1: disarm without producing a pulse.
- `edge_sel_i` input 2: trigger mode. 00 = rising edge, 01 = falling edge, 10 = either edge, 11 = high level.
- `filter_len_i` input 8: debounce length. The synchronized input must differ from the filtered value for `filter_len_i`+1 consecutive cycles before the filtered value changes.
- `timeout_i` input CNT_W: maximum number of cycles in ARMED. A value of 0 disables the timeout.
- `armed_o` output 1: high while in ARMED.
- `trig_o` output 1: one-cycle pulse when a qualified trigger is detected.
- `timeout_o` output 1: one-cycle pulse when the timeout expires.
- `latency_o` output CNT_W: ARMED cycle count captured at trigger. It is held until the next arm.
- `level_o` output 1: current filtered input level.

## Operation
Input filter (runs in all states):
- The synchronizer chain, `f`, the filter counter, and the previous-value register reset to 0.
- `s` = synchronizer output.
- Each cycle where `s != f`, the filter counter increments. When the counter equals `filter_len_i`, `f <= s` and the counter clears.
- Any cycle where `s == f` clears the counter.
- Edge events are derived from `f` compared against its one-cycle-delayed copy `f_q`.
- `filter_len_i` is used live, not latched.

State machine (encoding lives in the package):
- IDLE:
  - Outputs: `armed_o` = 0.
  - On `arm_i`=1 and `abort_i`=0: go to ARMED.
  - On arm acceptance: latch `edge_sel_i` and `timeout_i`, clear the cycle counter to 0, clear `latency_o`.
- ARMED:
  - Outputs: `armed_o` = 1.
  - The cycle counter increments every cycle and saturates at all-ones.
  - A match occurs under any of these conditions:
    - mode 00: `f & ~f_q`
    - mode 01: `~f & f_q`
    - mode 10: `f ^ f_q`
    - mode 11: `f`
  - On a match: `trig_o` <= 1 for one cycle, `latency_o` <= counter value, go to IDLE.
  - Else if the latched timeout is nonzero and the counter equals it: `timeout_o` <= 1 for one cycle, go to IDLE.
- Priority, highest first: `abort_i`, then trigger, then timeout. If `abort_i` and a match occur in the same cycle, the block returns to IDLE with no pulse.
- `arm_i` while ARMED is ignored.
- A second qualified edge is never reported without re-arming.
- Mode 11 with `f` already high at arm fires on the first ARMED cycle.
- Edge modes ignore any edge whose `f` transition landed on the arm-acceptance cycle itself. The first evaluated `f_q` is the value in the first ARMED cycle.

Reset values: all outputs 0, state IDLE. A `rst_n` assertion mid-ARMED returns the block to IDLE on the next edge with no pulse.

## Timing
- Detection latency:
  - Edge modes: with the new `trig_i` level first sampled at edge k, `trig_o` is high during cycle k + SYNC_STAGES + `filter_len_i` + 1. It is registered one cycle after `f` updates.
  - Level mode: `f` must be high at least one cycle into ARMED.
- `armed_o` rises the cycle after `arm_i` is sampled and falls the cycle after the trigger/timeout/abort decision.
- In every case `trig_o`, `timeout_o`, and the fall of `armed_o` are in the same cycle.
- Glitches shorter than `filter_len_i`+1 cycles after synchronization are never reported.
- The counter is CNT_W bits and saturating. `latency_o` is the number of cycles from the first ARMED cycle (value 0) to the trigger cycle.

## Structure
- Shared package `glitcher_pkg`:
  - Trigger-mode constants: `TRIG_RISE`, `TRIG_FALL`, `TRIG_BOTH`, `TRIG_LEVEL`.
  - Monitor state encoding.
  - Default `CNT_W`.
- Sub-module `input_filter`: SYNC_STAGES synchronizer plus debounce counter. It outputs `f` and `f_q`, and it is reusable for other target-facing inputs.
- The top level holds the FSM and counters only.

## Test plan
- Rising mode, `filter_len_i`=0, SYNC_STAGES=2, arm, raise `trig_i` 10 cycles later:
  - `trig_o` is a single pulse 3 cycles after the first sampling edge.
  - `latency_o` is about 10.
  - `armed_o` falls in the same cycle.
- `filter_len_i`=4, apply 3-cycle and 4-cycle high glitches, then a 5-cycle high:
  - No pulse for either glitch.
  - The 5-cycle high produces exactly one `trig_o`, 7 cycles after sampling.
- `timeout_i`=20 with no input activity:
  - `timeout_o` is pulsed on the cycle the counter equals 20.
  - `trig_o` is never asserted.
  - `latency_o` = 0.
- Timeout and edge in the same cycle:
  - Only `trig_o` is asserted.
  - Repeat with `abort_i` high as well: no pulse, IDLE.
- Level mode with `trig_i` held high before arm:
  - `trig_o` on the first ARMED cycle, `latency_o` = 0.
  - Falling mode, same setup: no trigger until a falling edge occurs.
- Assert `rst_n`=0 mid-ARMED with an edge in flight:
  - All outputs are 0 the next cycle.
  - No `trig_o` after release until re-armed.

Source files
------------

// File: rtl/glitcher_pkg.sv
// glitcher_pkg: shared trigger-mode constants, monitor state encoding and defaults.
// Contents:
//   DEF_CNT_W   - default width of the timeout/latency counters
//   trig_mode_e - TRIG_RISE / TRIG_FALL / TRIG_BOTH / TRIG_LEVEL
//   mon_state_e - trigger monitor FSM states
//   trig_match  - qualifies filtered level f against its delayed copy fp for a mode
package glitcher_pkg;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        TRIG_RISE  = 2'b00,
        TRIG_FALL  = 2'b01,
        TRIG_BOTH  = 2'b10,
        TRIG_LEVEL = 2'b11
    } trig_mode_e;

    typedef enum logic {
        MON_IDLE  = 1'b0,
        MON_ARMED = 1'b1
    } mon_state_e;

    function automatic logic trig_match(trig_mode_e m, logic f, logic fp);
        return (m == TRIG_RISE) ? (f & ~fp) :
               (m == TRIG_FALL) ? (~f & fp) :
               (m == TRIG_BOTH) ? (f ^ fp)  : f;
    endfunction
endpackage

// File: rtl/trigger_monitor_if.sv
// trigger_monitor_if: control/status bundle between the glitcher controller and the trigger monitor.
// Signals:
//   trig_i       - raw asynchronous line from the target
//   arm_i        - arm request (honoured only when idle)
//   abort_i      - disarm without a pulse
//   edge_sel_i   - trigger mode (trig_mode_e encoding)
//   filter_len_i - debounce length, filtered value changes after filter_len_i+1 differing cycles
//   timeout_i    - max ARMED cycles, 0 disables
//   armed_o      - high while armed
//   trig_o       - one-cycle qualified trigger pulse
//   timeout_o    - one-cycle timeout pulse
//   latency_o    - ARMED cycle count captured at trigger
//   level_o      - current filtered input level
// Modports: master drives the requests, slave is the monitor.
interface trigger_monitor_if
    import glitcher_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             trig_i;
    logic             arm_i;
    logic             abort_i;
    logic [1:0]       edge_sel_i;
    logic [7:0]       filter_len_i;
    logic [CNT_W-1:0] timeout_i;
    logic             armed_o;
    logic             trig_o;
    logic             timeout_o;
    logic [CNT_W-1:0] latency_o;
    logic             level_o;

    modport master (
        output trig_i, arm_i, abort_i, edge_sel_i, filter_len_i, timeout_i,
        input  armed_o, trig_o, timeout_o, latency_o, level_o
    );

    modport slave (
        input  trig_i, arm_i, abort_i, edge_sel_i, filter_len_i, timeout_i,
        output armed_o, trig_o, timeout_o, latency_o, level_o
    );
endinterface

// File: rtl/input_filter.sv
// input_filter: synchronizer plus debounce for an asynchronous target-facing input.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   d_i        - raw asynchronous input
//   len_i      - debounce length, output follows after len_i+1 consecutive differing cycles
//   f_o        - filtered level
//   f_prev_o   - filtered level delayed by one cycle (for edge detection)
module input_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_i,
    input  logic [7:0] len_i,
    output logic       f_o,
    output logic       f_prev_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             cnt_q, cnt_d;
    logic                   f_q, f_d, fp_q;
    logic                   s, diff, done;

    assign s    = sync_q[SYNC_STAGES-1];
    assign diff = s != f_q;
    // >= rather than == so a live shrink of len_i below the running count
    // still commits instead of letting the counter wrap.
    assign done = diff && (cnt_q >= len_i);

    always_comb begin
        cnt_d = (diff && !done) ? cnt_q + 8'd1 : 8'd0;
        f_d   = done ? s : f_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            f_q    <= 1'b0;
            fp_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            cnt_q  <= cnt_d;
            f_q    <= f_d;
            fp_q   <= f_q;
        end
    end

    assign f_o      = f_q;
    assign f_prev_o = fp_q;
endmodule

// File: rtl/trigger_monitor.sv
// trigger_monitor: turns a qualified edge/level on the target's trigger line into a one-shot pulse.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - trigger_monitor_if slave: arm/abort/mode/filter/timeout in,
//                armed/trig/timeout pulses, captured latency and filtered level out
module trigger_monitor
    import glitcher_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic            clk,
    input logic            rst_n,
    trigger_monitor_if.slave bus
);
    mon_state_e       state_q, state_d;
    trig_mode_e       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, tmo_q, tmo_d, lat_q, lat_d;
    logic             trig_q, trig_d, tmo_hit_q, tmo_hit_d;
    logic             f, f_prev, match;

    input_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.trig_i),
        .len_i   (bus.filter_len_i),
        .f_o     (f),
        .f_prev_o(f_prev)
    );

    assign match = trig_match(mode_q, f, f_prev);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        lat_d     = lat_q;
        trig_d    = 1'b0;
        tmo_hit_d = 1'b0;
        if (state_q == MON_IDLE) begin
            if (bus.arm_i && !bus.abort_i) begin
                state_d = MON_ARMED;
                mode_d  = trig_mode_e'(bus.edge_sel_i);
                tmo_d   = bus.timeout_i;
                cnt_d   = '0;
                lat_d   = '0;
            end
        end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            // abort beats trigger beats timeout
            if (bus.abort_i) begin
                state_d = MON_IDLE;
            end else if (match) begin
                state_d = MON_IDLE;
                trig_d  = 1'b1;
                lat_d   = cnt_q;
            end else if (tmo_q != '0 && cnt_q == tmo_q) begin
                state_d   = MON_IDLE;
                tmo_hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MON_IDLE;
            mode_q    <= TRIG_RISE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            lat_q     <= '0;
            trig_q    <= 1'b0;
            tmo_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            lat_q     <= lat_d;
            trig_q    <= trig_d;
            tmo_hit_q <= tmo_hit_d;
        end
    end

    assign bus.armed_o   = state_q == MON_ARMED;
    assign bus.trig_o    = trig_q;
    assign bus.timeout_o = tmo_hit_q;
    assign bus.latency_o = lat_q;
    assign bus.level_o   = f;
endmodule

// File: tb/tb_trigger_monitor.sv
// tb_trigger_monitor: directed, table-driven check of trigger_monitor with SYNC_STAGES=2.
module tb_trigger_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    trigger_monitor_if #(.CNT_W(16)) bus ();

    trigger_monitor #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // One arming per row. Positions p count edges after the arm-accept edge A (p=0).
    // trig_i flips to ~init so its new level is first sampled at edge A+d (d=0: never),
    // and flips back after w cycles (w=0: held). *_at = p at which the pulse is seen, -1 none.
    typedef struct {
        string nm;
        int    mode;
        int    flen;
        int    tmo;
        bit    init;
        int    d;
        int    w;
        int    trig_at;
        int    tmo_at;
        int    lat;
    } row_t;

    row_t rows[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int ntrig, ntmo, trig_at, tmo_at, fall_at, exp_fall;
        rows[0]  = '{"rise_f0",        0, 0,  0, 1'b0, 10, 0, 13, -1, 12};
        rows[1]  = '{"glitch3",        0, 4,  0, 1'b0,  5, 3, -1, -1,  0};
        rows[2]  = '{"glitch4",        0, 4,  0, 1'b0,  5, 4, -1, -1,  0};
        rows[3]  = '{"pulse5",         0, 4,  0, 1'b0,  5, 5, 12, -1, 11};
        rows[4]  = '{"timeout20",      0, 0, 20, 1'b0,  0, 0, -1, 21,  0};
        rows[5]  = '{"tmo_vs_edge",    0, 0, 10, 1'b0,  8, 0, 11, -1, 10};
        rows[6]  = '{"tmo_before",     0, 0,  9, 1'b0,  8, 0, -1, 10,  0};
        rows[7]  = '{"level_pre",      3, 0,  0, 1'b1,  0, 0,  1, -1,  0};
        rows[8]  = '{"fall_hold",      1, 0,  0, 1'b1,  0, 0, -1, -1,  0};
        rows[9]  = '{"fall_edge",      1, 0,  0, 1'b1,  6, 0,  9, -1,  8};
        rows[10] = '{"both_once",      2, 0,  0, 1'b0,  4, 5,  7, -1,  6};
        rows[11] = '{"both_fall",      2, 0,  0, 1'b1,  4, 0,  7, -1,  6};
        rows[12] = '{"rise_f2",        0, 2,  0, 1'b0,  3, 0,  8, -1,  7};
        rows[13] = '{"rise_no_fall",   0, 0,  0, 1'b1,  4, 0, -1, -1,  0};

        bus.trig_i = 1'b0;
        bus.arm_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.edge_sel_i = 2'd0;
        bus.filter_len_i = 8'd0;
        bus.timeout_i = 16'd0;
        repeat (3) tick();
        chk("rst_armed", int'(bus.armed_o), 0);
        chk("rst_trig", int'(bus.trig_o), 0);
        chk("rst_timeout", int'(bus.timeout_o), 0);
        chk("rst_latency", int'(bus.latency_o), 0);
        chk("rst_level", int'(bus.level_o), 0);
        rst_n = 1'b1;

        foreach (rows[i]) begin
            bus.trig_i = rows[i].init;
            bus.edge_sel_i = 2'(rows[i].mode);
            bus.filter_len_i = 8'(rows[i].flen);
            bus.timeout_i = 16'(rows[i].tmo);
            repeat (12) tick();
            bus.arm_i = 1'b1;
            tick();
            bus.arm_i = 1'b0;
            chk({rows[i].nm, "_armed_rise"}, int'(bus.armed_o), 1);
            ntrig = 0; ntmo = 0; trig_at = -1; tmo_at = -1; fall_at = -1;
            for (int p = 0; p <= 30; p++) begin
                if (p > 0) tick();
                if (bus.trig_o) begin ntrig++; if (trig_at < 0) trig_at = p; end
                if (bus.timeout_o) begin ntmo++; if (tmo_at < 0) tmo_at = p; end
                if (!bus.armed_o && fall_at < 0) fall_at = p;
                if (rows[i].d > 0 && p == rows[i].d - 1) bus.trig_i = ~rows[i].init;
                if (rows[i].d > 0 && rows[i].w > 0 && p == rows[i].d - 1 + rows[i].w) bus.trig_i = rows[i].init;
            end
            exp_fall = rows[i].trig_at >= 0 ? rows[i].trig_at : rows[i].tmo_at;
            chk({rows[i].nm, "_trig_cnt"}, ntrig, rows[i].trig_at >= 0 ? 1 : 0);
            chk({rows[i].nm, "_trig_at"}, trig_at, rows[i].trig_at);
            chk({rows[i].nm, "_tmo_cnt"}, ntmo, rows[i].tmo_at >= 0 ? 1 : 0);
            chk({rows[i].nm, "_tmo_at"}, tmo_at, rows[i].tmo_at);
            chk({rows[i].nm, "_armed_fall"}, fall_at, exp_fall);
            chk({rows[i].nm, "_latency"}, int'(bus.latency_o), rows[i].lat);
            bus.abort_i = 1'b1;
            tick();
            bus.abort_i = 1'b0;
            chk({rows[i].nm, "_idle_after"}, int'(bus.armed_o), 0);
        end

        // abort, trigger match and timeout all land in the same ARMED cycle (cnt=7)
        bus.trig_i = 1'b0;
        bus.edge_sel_i = 2'd0;
        bus.filter_len_i = 8'd0;
        bus.timeout_i = 16'd7;
        repeat (12) tick();
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        ntrig = 0; ntmo = 0;
        for (int p = 1; p <= 20; p++) begin
            tick();
            if (bus.trig_o) ntrig++;
            if (bus.timeout_o) ntmo++;
            if (p == 8) chk("abort_armed_fall", int'(bus.armed_o), 0);
            if (p == 4) bus.trig_i = 1'b1;
            if (p == 7) bus.abort_i = 1'b1;
            if (p == 8) bus.abort_i = 1'b0;
        end
        chk("abort_trig_cnt", ntrig, 0);
        chk("abort_tmo_cnt", ntmo, 0);
        chk("abort_idle", int'(bus.armed_o), 0);

        // reset lands on the edge where the filtered rise would have been seen
        bus.trig_i = 1'b0;
        bus.timeout_i = 16'd0;
        repeat (12) tick();
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        ntrig = 0;
        for (int p = 1; p <= 20; p++) begin
            tick();
            if (p == 4) begin
                chk("rstmid_armed", int'(bus.armed_o), 0);
                chk("rstmid_trig", int'(bus.trig_o), 0);
                chk("rstmid_timeout", int'(bus.timeout_o), 0);
                chk("rstmid_latency", int'(bus.latency_o), 0);
                chk("rstmid_level", int'(bus.level_o), 0);
                rst_n = 1'b1;
            end else if (bus.trig_o) begin
                ntrig++;
            end
            if (p == 1) bus.trig_i = 1'b1;
            if (p == 3) rst_n = 1'b0;
        end
        chk("rstmid_no_trig", ntrig, 0);
        chk("rstmid_idle", int'(bus.armed_o), 0);
        chk("rstmid_level_back", int'(bus.level_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
